ram_loader: RTL

Byte-stream loader that sits directly upstream of the 8-word RAM and owns its write port during a load. It accepts bytes over a valid/ready handshake, packs each pair high-byte-first into a 16-bit word, and writes the words to consecutive RAM addresses. The address wraps at the top of the RAM. While loading, it keeps a running 16-bit checksum. It is used to preload programs and data before the CPU is released.

---
 rtl/ram_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: byte-stream loader for the program/data RAM.
// Accepts bytes over valid/ready, packs pairs high-byte-first into 16-bit
// words, writes them to consecutive (wrapping) RAM addresses and keeps a
// running 16-bit checksum of the words written in the current load.
module ram_loader #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_load,
  output logic [15:0]           mem_in,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH:0]   rem_q;
  logic [ADDR_WIDTH:0]   rem_d;
  logic [15:0]           csum_d;
  logic [7:0]            hi_q;
  logic                  accept;
  logic                  enter_write;

  // Modulo-2^16 accumulate: the carry out of the checksum is dropped.
  function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                           input logic [15:0] word);
    logic [16:0] sum;
    sum = {1'b0, acc} + {1'b0, word};
    return sum[15:0];
  endfunction

  // byte_ready is registered and high exactly in HI/LO, so this is the
  // transfer condition the producer sees on the same edge.
  assign accept      = byte_valid & byte_ready;
  assign enter_write = (state_q == S_LO) & accept;

  // Next-state, address, remaining-count and checksum update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = checksum;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_count;
          csum_d  = '0;
          state_d = (word_count == '0) ? S_DONE : S_HI;
        end
      end
      S_HI: begin
        if (accept) state_d = S_LO;
      end
      S_LO: begin
        if (accept) state_d = S_WRITE;
      end
      S_WRITE: begin
        // mem_in already holds {hi, lo} for this word.
        csum_d  = csum_add(checksum, mem_in);
        addr_d  = addr_q + ADDR_ONE;
        rem_d   = rem_q - REM_ONE;
        state_d = (rem_q == REM_ONE) ? S_DONE : S_HI;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, write address and words still to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // High byte holding register; a half-built word is simply never used
  // after a reset, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    if ((state_q == S_HI) && accept) hi_q <= byte_data;
  end

  // Registered outputs, derived from the state being entered so they line
  // up with that state's cycle. Address/data only move on a new write so
  // they hold the last write's values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_load    <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
      checksum    <= '0;
    end else begin
      byte_ready <= (state_d == S_HI) || (state_d == S_LO);
      busy       <= (state_d == S_HI) || (state_d == S_LO) ||
                    (state_d == S_WRITE);
      done       <= (state_d == S_DONE);
      mem_load   <= enter_write;
      checksum   <= csum_d;
      if (enter_write) begin
        mem_address <= addr_q;
        mem_in      <= {hi_q, byte_data};
      end
    end
  end

endmodule
